// File: rtl/timer_alarm.sv
// Compare/alarm block for a free-running 2*DATA_W timer. It supports one-shot and
// periodic interrupts, a pending irq flag and a saturating count of missed matches.
module timer_alarm #(
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cke_i,
  input  logic [2*DATA_W-1:0] timer_value_i,
  input  logic                cfg_wr_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [DATA_W-1:0]   cfg_wdata_i,
  input  logic                irq_ack_i,
  output logic                irq_o,
  output logic [1:0]          state_o,
  output logic [7:0]          miss_cnt_o
);
  localparam int TW = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [TW-1:0]     r_cmp;
  logic [TW-1:0]     w_cmp_next;
  logic [TW-1:0]     w_diff;
  logic [DATA_W-1:0] r_staging;
  logic [DATA_W-1:0] r_period;
  logic              r_periodic;
  logic              r_irq;
  logic              w_irq_next;
  logic [7:0]        r_miss;
  logic [7:0]        w_miss_next;
  logic              w_wr_low;
  logic              w_wr_high;
  logic              w_wr_period;
  logic              w_wr_ctrl;
  logic              w_match;
  logic              w_reload;

  assign w_wr_low    = cfg_wr_i && (cfg_addr_i == 2'd0);
  assign w_wr_high   = cfg_wr_i && (cfg_addr_i == 2'd1);
  assign w_wr_period = cfg_wr_i && (cfg_addr_i == 2'd2);
  assign w_wr_ctrl   = cfg_wr_i && (cfg_addr_i == 2'd3);

  // The sign of the modular difference keeps the match correct across the timer wrap.
  // A CTRL write in the same cycle suppresses the match.
  assign w_diff   = timer_value_i - r_cmp;
  assign w_match  = (r_state == ST_ARMED) && cke_i && !w_diff[TW-1] && !w_wr_ctrl;
  assign w_reload = w_match && r_periodic && (r_period != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_wr_ctrl) begin
      w_state_next = cfg_wdata_i[0] ? ST_ARMED : ST_IDLE;
    end else begin
      case (r_state)
        ST_ARMED: if (w_match && !w_reload) w_state_next = ST_FIRED;
        ST_FIRED: if (irq_ack_i) w_state_next = ST_IDLE;
        default:  w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_irq_next  = r_irq;
    w_miss_next = r_miss;
    w_cmp_next  = r_cmp;
    if (w_wr_ctrl) begin
      w_miss_next = '0;
      if (!cfg_wdata_i[0]) w_irq_next = 1'b0;
    end else if (w_match) begin
      w_irq_next = 1'b1;
      if (r_irq && (r_miss != 8'hFF)) w_miss_next = r_miss + 8'd1;
    end else if (irq_ack_i) begin
      w_irq_next = 1'b0;
    end
    if (w_wr_high)     w_cmp_next = {cfg_wdata_i, r_staging};
    else if (w_reload) w_cmp_next = r_cmp + {{DATA_W{1'b0}}, r_period};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cmp      <= '0;
      r_staging  <= '0;
      r_period   <= '0;
      r_periodic <= 1'b0;
      r_irq      <= 1'b0;
      r_miss     <= '0;
    end else begin
      r_cmp <= w_cmp_next;
      r_irq <= w_irq_next;
      r_miss <= w_miss_next;
      if (w_wr_low)    r_staging  <= cfg_wdata_i;
      if (w_wr_period) r_period   <= cfg_wdata_i;
      if (w_wr_ctrl)   r_periodic <= cfg_wdata_i[1];
    end
  end

  assign irq_o      = r_irq;
  assign state_o    = r_state;
  assign miss_cnt_o = r_miss;
endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm. A behavioural model is checked every cycle,
// and literal expectations pin the key scenarios.
module tb_timer_alarm;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cke;
  logic [63:0] tv;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic        irq;
  logic [1:0]  state;
  logic [7:0]  miss;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state, written only by the model process
  logic [63:0] m_cmp;
  logic [31:0] m_stage;
  logic [31:0] m_period;
  bit          m_periodic;
  bit          m_irq;
  int          m_miss;
  int          m_state;

  logic [63:0] rises[$];
  logic [63:0] exp_per[5] = '{64'd100, 64'd150, 64'd200, 64'd250, 64'd300};

  timer_alarm #(.DATA_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .timer_value_i(tv),
    .cfg_wr_i(wr), .cfg_addr_i(addr), .cfg_wdata_i(wdata), .irq_ack_i(ack),
    .irq_o(irq), .state_o(state), .miss_cnt_o(miss)
  );

  always #5 clk = ~clk;

  // The timer has reached the compare point when it is at most half the range past it.
  function automatic bit reached(input logic [63:0] t, input logic [63:0] c);
    return (t - c) < 64'h8000_0000_0000_0000;
  endfunction

  function automatic bit model_hit();
    return (m_state == 1) && cke && reached(tv, m_cmp) && !(wr && addr == 2'd3);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cmp <= '0; m_stage <= '0; m_period <= '0; m_periodic <= 1'b0;
      m_irq <= 1'b0; m_miss <= 0; m_state <= 0;
    end else begin
      if (wr && addr == 2'd0) m_stage <= wdata;
      if (wr && addr == 2'd2) m_period <= wdata;
      if (wr && addr == 2'd1) m_cmp <= {wdata, m_stage};
      else if (model_hit() && m_periodic && m_period != 0) m_cmp <= m_cmp + m_period;
      if (wr && addr == 2'd3) begin
        m_state <= wdata[0] ? 1 : 0;
        m_periodic <= wdata[1];
        m_miss <= 0;
        if (!wdata[0]) m_irq <= 1'b0;
      end else if (model_hit()) begin
        m_irq <= 1'b1;
        if (m_irq) m_miss <= (m_miss < 255) ? m_miss + 1 : 255;
        if (!(m_periodic && m_period != 0)) m_state <= 2;
      end else if (ack) begin
        m_irq <= 1'b0;
        if (m_state == 2) m_state <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (irq !== m_irq) begin
        bad++;
        $display("FAIL cyc_irq t=%0t got=%b want=%b", $time, irq, m_irq);
      end
      total++;
      if (state !== 2'(m_state)) begin
        bad++;
        $display("FAIL cyc_state t=%0t got=%0d want=%0d", $time, state, m_state);
      end
      total++;
      if (miss !== 8'(m_miss)) begin
        bad++;
        $display("FAIL cyc_miss t=%0t got=%0d want=%0d", $time, miss, m_miss);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    cyc();
    wr = 1'b0;
  endtask

  task automatic ramp(input logic [63:0] start, input int n, input bit auto_ack);
    logic prev;
    for (int i = 0; i < n; i++) begin
      tv = start + 64'(i);
      ack = auto_ack && m_irq;
      prev = irq;
      cyc();
      if (irq === 1'b1 && prev !== 1'b1) rises.push_back(tv);
    end
    ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cke = 1'b1; tv = '0; wr = 1'b0; addr = '0; wdata = '0; ack = 1'b0;
    cyc(); cyc(); cyc();
    check("rst_irq", irq, 0);
    check("rst_state", state, 0);
    check("rst_miss", miss, 0);
    chk_en = 1'b1;
    rst_n = 1'b1;

    // One-shot at 0x1_0000_0010
    write(2'd0, 32'h10); write(2'd1, 32'h1); write(2'd3, 32'h1);
    check("os_armed", state, 1);
    ramp(64'h1_0000_0000, 16, 1'b0);
    check("os_before", irq, 0);
    ramp(64'h1_0000_0010, 1, 1'b0);
    check("os_irq", irq, 1);
    check("os_fired", state, 2);
    ack = 1'b1; cyc(); ack = 1'b0;
    check("os_ack_irq", irq, 0);
    check("os_ack_state", state, 0);

    // Periodic: compare 100, period 50
    tv = '0;
    write(2'd2, 32'd50); write(2'd0, 32'd100); write(2'd1, 32'd0); write(2'd3, 32'h3);
    rises.delete();
    ramp(64'd0, 301, 1'b1);
    check("per_count", 64'(rises.size()), 5);
    for (int i = 0; i < 5 && i < rises.size(); i++) check($sformatf("per_at%0d", i), rises[i], exp_per[i]);
    check("per_miss", miss, 0);
    write(2'd3, 32'h0);
    check("per_disarm_state", state, 0);
    check("per_disarm_irq", irq, 0);

    // Wrap across 2^64-1
    tv = 64'hFFFF_FFFF_FFFF_FFEC;
    write(2'd0, 32'hFFFF_FFF6); write(2'd1, 32'hFFFF_FFFF); write(2'd2, 32'd20); write(2'd3, 32'h3);
    rises.delete();
    ramp(64'hFFFF_FFFF_FFFF_FFF1, 30, 1'b1);
    check("wrap_count", 64'(rises.size()), 2);
    if (rises.size() == 2) begin
      check("wrap_first", rises[0], 64'hFFFF_FFFF_FFFF_FFF6);
      check("wrap_second", rises[1], 64'd10);
    end
    write(2'd3, 32'h0);

    // CMP_LOW stages only; CMP_HIGH beats a reload in the same cycle
    tv = '0;
    write(2'd0, 32'd50); write(2'd1, 32'd0); write(2'd0, 32'd80); write(2'd2, 32'd10); write(2'd3, 32'h3);
    tv = 64'd50; wr = 1'b1; addr = 2'd1; wdata = 32'd0;
    cyc();
    wr = 1'b0;
    check("hi_win_irq", irq, 1);
    check("hi_win_state", state, 1);
    rises.delete();
    ramp(64'd51, 35, 1'b1);
    check("hi_win_count", 64'(rises.size()), 1);
    if (rises.size() == 1) check("hi_win_at", rises[0], 64'd80);
    write(2'd3, 32'h0);

    // Miss counter saturation with period 1 and no ack
    tv = '0;
    write(2'd0, 32'd5); write(2'd1, 32'd0); write(2'd2, 32'd1); write(2'd3, 32'h3);
    ramp(64'd5, 10, 1'b0);
    check("miss_9", miss, 9);
    ramp(64'd15, 290, 1'b0);
    check("miss_sat", miss, 255);
    tv = 64'd305; ack = 1'b1;
    cyc();
    ack = 1'b0;
    check("match_ack_irq", irq, 1);
    check("match_ack_miss", miss, 255);
    write(2'd3, 32'h0);
    check("ctrl_clr_miss", miss, 0);

    // Clock-enable gating
    tv = '0;
    write(2'd0, 32'd20); write(2'd1, 32'd0); write(2'd2, 32'd0); write(2'd3, 32'h1);
    cke = 1'b0;
    ramp(64'd0, 31, 1'b0);
    check("cke_off_irq", irq, 0);
    check("cke_off_state", state, 1);
    cke = 1'b1;
    cyc();
    check("cke_on_irq", irq, 1);
    check("cke_on_state", state, 2);
    ack = 1'b1; cyc(); ack = 1'b0;
    check("cke_ack_state", state, 0);

    // Reset while armed
    tv = '0;
    write(2'd0, 32'd40); write(2'd1, 32'd0); write(2'd3, 32'h1);
    check("rst_mid_armed", state, 1);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    check("rst_mid_state", state, 0);
    check("rst_mid_irq", irq, 0);
    rises.delete();
    ramp(64'd0, 60, 1'b0);
    check("rst_mid_noirq", 64'(rises.size()), 0);
    check("rst_mid_idle", state, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timer_alarm.md
TIMER_ALARM -- requirements
Module: timer_alarm

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the configuration data width; the timer value width is 2*DATA_W.
REQ-002 The block SHALL have port clk_i, input, 1, system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port cke_i, input, 1, clock enable; match evaluation is gated by it.
REQ-005 The block SHALL have port timer_value_i, input, 2*DATA_W, free-running count from the upstream 64-bit timer.
REQ-006 The block SHALL have port cfg_wr_i, input, 1, single-cycle configuration write strobe.
REQ-007 The block SHALL have port cfg_addr_i, input, 2, register select: 0 CMP_LOW, 1 CMP_HIGH, 2 PERIOD, 3 CTRL.
REQ-008 The block SHALL have port cfg_wdata_i, input, DATA_W, configuration write data.
REQ-009 The block SHALL have port irq_ack_i, input, 1, interrupt acknowledge pulse.
REQ-010 The block SHALL have port irq_o, output, 1, registered interrupt pending flag.
REQ-011 The block SHALL have port state_o, output, 2, current FSM state: 0 IDLE, 1 ARMED, 2 FIRED.
REQ-012 The block SHALL have port miss_cnt_o, output, 8, saturating count of matches that occurred while irq_o was already set.

Function
REQ-013 A CMP_LOW write SHALL load a DATA_W staging register only; the active compare value SHALL be unchanged.
REQ-014 A CMP_HIGH write SHALL commit {wdata, staging} atomically into the 2*DATA_W compare register in the same cycle.
REQ-015 A PERIOD write SHALL load a DATA_W period register; the period is zero-extended to 2*DATA_W for all arithmetic.
REQ-016 A CTRL write SHALL behave as follows: bit0=1 arms; bit0=0 disarms; bit1 sets periodic mode. The periodic bit SHALL be latched on every CTRL write.
REQ-017 Configuration writes SHALL take effect regardless of cke_i.
REQ-018 Match SHALL be defined as bit (2*DATA_W-1) of (timer_value_i - compare), computed modulo 2^(2*DATA_W), being 0, which makes the comparison wrap-safe.
REQ-019 Match SHALL be evaluated only in ARMED with cke_i=1.
REQ-020 IDLE SHALL go to ARMED on a CTRL write with bit0=1; all other events are ignored in IDLE.
REQ-021 In ARMED, on a match in periodic mode with PERIOD != 0: stay in ARMED and set compare to compare+PERIOD (wrapping).
REQ-022 In ARMED, on a match in one-shot mode or with PERIOD=0: go to FIRED.
REQ-023 FIRED SHALL go to IDLE on irq_ack_i=1.
REQ-024 A CTRL write with bit0=0 SHALL force IDLE from any state and clear irq_o in the same cycle.
REQ-025 A CTRL write with bit0=1 while in ARMED or FIRED SHALL force ARMED.
REQ-026 A CTRL write SHALL take priority over a match and over irq_ack_i in the same cycle.
REQ-027 irq_o SHALL rise on the clock edge that registers a match, with one cycle of latency from timer_value_i reaching compare.
REQ-028 irq_ack_i SHALL clear irq_o; if a match and irq_ack_i occur in the same cycle, irq_o SHALL remain 1.
REQ-029 A match with irq_o already 1 SHALL increment miss_cnt_o, saturating at 255.
REQ-030 Any CTRL write SHALL clear miss_cnt_o.
REQ-031 A CMP_HIGH write in the same cycle as a periodic reload SHALL win; the written value is loaded and no increment is applied.

Reset
REQ-032 While rst_n_i=0 at a rising edge, the block SHALL clear compare, staging, PERIOD, periodic bit and miss_cnt_o to 0, set irq_o to 0, and set state_o to IDLE.
REQ-033 Reset SHALL override every concurrent write, match or acknowledge, including a reset taken while in ARMED.

Verification
REQ-034 One-shot: CMP=0x0000_0001_0000_0010, arm, ramp timer from 0x0000_0001_0000_0000 -> irq_o=1 one cycle after value 0x..10, state FIRED; ack -> irq_o=0, state IDLE.
REQ-035 Periodic: CMP=100, PERIOD=50, periodic arm, timer ramps 0..300 with ack after each irq -> irq at 100, 150, 200, 250, 300; miss_cnt_o=0.
REQ-036 Wrap: CMP=2^64-10, PERIOD=20, timer ramps across 2^64-1 -> irq at 2^64-10, then compare=10 and irq at timer=10, with no spurious irq at the wrap.
REQ-037 Missed and simultaneous events: periodic with PERIOD=1 and no ack for 300 cycles -> miss_cnt_o saturates at 255; match and ack in the same cycle -> irq_o stays 1.
REQ-038 Gating and reset: cke_i=0 while timer passes CMP -> no irq until cke_i=1, then irq.
REQ-039 Reset mid-operation: rst_n_i=0 while ARMED -> next cycle state_o=0, irq_o=0, and a later timer pass of the old CMP raises no irq.
